riscv_core_wb_arb: RTL

//  Arbitrates the single register-file write port (we3/a3/wd3) between the in-order pipeline writeback (P)
//  and the multi-cycle mul/div unit (M). Keeps a 32-entry scoreboard of registers with M results pending,
//  for hazard detection in decode. Sits between the writeback stage / M unit and riscv_core_rf.

---
 rtl/riscv_core_wb_arb_if.sv | 35 +++
 rtl/riscv_core_wb_arb.sv | 91 +++++++++
 2 files changed

// File: rtl/riscv_core_wb_arb_if.sv
// riscv_core_wb_arb_if: writeback/M-unit request, scoreboard and RF write-port signals of the writeback arbiter.
interface riscv_core_wb_arb_if #(
  parameter int XLEN = 64
);
  logic            i_p_vld;
  logic [4:0]      i_p_rd;
  logic [XLEN-1:0] i_p_wd;
  logic            i_m_vld;
  logic [4:0]      i_m_rd;
  logic [XLEN-1:0] i_m_wd;
  logic            o_m_rdy;
  logic            o_p_stall;
  logic            i_md_issue_vld;
  logic [4:0]      i_md_issue_rd;
  logic            o_md_issue_rdy;
  logic [4:0]      i_rs1;
  logic [4:0]      i_rs2;
  logic            o_sb_hit1;
  logic            o_sb_hit2;
  logic            o_rf_we3;
  logic [4:0]      o_rf_a3;
  logic [XLEN-1:0] o_rf_wd3;
  modport slave (
    input  i_p_vld, i_p_rd, i_p_wd, i_m_vld, i_m_rd, i_m_wd,
    input  i_md_issue_vld, i_md_issue_rd, i_rs1, i_rs2,
    output o_m_rdy, o_p_stall, o_md_issue_rdy, o_sb_hit1, o_sb_hit2,
    output o_rf_we3, o_rf_a3, o_rf_wd3
  );
  modport master (
    output i_p_vld, i_p_rd, i_p_wd, i_m_vld, i_m_rd, i_m_wd,
    output i_md_issue_vld, i_md_issue_rd, i_rs1, i_rs2,
    input  o_m_rdy, o_p_stall, o_md_issue_rdy, o_sb_hit1, o_sb_hit2,
    input  o_rf_we3, o_rf_a3, o_rf_wd3
  );
endinterface

// File: rtl/riscv_core_wb_arb.sv
// riscv_core_wb_arb: arbitrates the RF write port between pipeline writeback and the mul/div unit,
// with starvation protection for M and a scoreboard of registers awaiting M results.
module riscv_core_wb_arb #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int MD_MAX_OUT   = 2
) (
  input logic                  i_wb_clk,
  input logic                  i_wb_rst_n,
  riscv_core_wb_arb_if.slave   bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(MD_MAX_OUT + 1);
  typedef enum logic {ST_NORMAL, ST_STARVED} state_t;
  state_t          r_state, w_state_nxt;
  logic [SW-1:0]   r_starve, w_starve_nxt;
  logic [31:0]     r_busy, w_busy_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_we3;
  logic [4:0]      r_a3;
  logic [XLEN-1:0] r_wd3;
  logic            w_p_win;
  logic            w_m_rdy;
  logic            w_issue_rdy;
  logic            w_iss;
  always_comb begin
    w_p_win      = (r_state == ST_NORMAL) && bus.i_p_vld;
    w_m_rdy      = bus.i_m_vld && !w_p_win;
    w_state_nxt  = r_state;
    w_starve_nxt = '0;
    if (r_state == ST_NORMAL) begin
      if (bus.i_m_vld && !w_m_rdy) begin
        // the losing cycle that reaches the limit triggers the stall next cycle
        if (r_starve == SW'(STARVE_LIMIT - 1))
          w_state_nxt = ST_STARVED;
        else
          w_starve_nxt = r_starve + 1'b1;
      end
    end else if (w_m_rdy || !bus.i_m_vld) begin
      w_state_nxt = ST_NORMAL;
    end
  end
  assign w_issue_rdy = r_cnt < CW'(MD_MAX_OUT);
  assign w_iss       = bus.i_md_issue_vld && w_issue_rdy;
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_m_rdy) w_busy_nxt[bus.i_m_rd] = 1'b0;
    if (w_iss) w_busy_nxt[bus.i_md_issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
    w_cnt_nxt = r_cnt;
    if (w_iss && !w_m_rdy)
      w_cnt_nxt = r_cnt + 1'b1;
    else if (!w_iss && w_m_rdy && r_cnt != '0)
      w_cnt_nxt = r_cnt - 1'b1;
  end
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      r_state  <= ST_NORMAL;
      r_starve <= '0;
      r_busy   <= '0;
      r_cnt    <= '0;
      r_we3    <= 1'b0;
      r_a3     <= '0;
      r_wd3    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_busy   <= w_busy_nxt;
      r_cnt    <= w_cnt_nxt;
      if (w_p_win) begin
        r_we3 <= |bus.i_p_rd;
        r_a3  <= bus.i_p_rd;
        r_wd3 <= bus.i_p_wd;
      end else if (w_m_rdy) begin
        r_we3 <= |bus.i_m_rd;
        r_a3  <= bus.i_m_rd;
        r_wd3 <= bus.i_m_wd;
      end else begin
        r_we3 <= 1'b0;
      end
    end
  end
  assign bus.o_m_rdy        = w_m_rdy;
  assign bus.o_p_stall      = r_state == ST_STARVED;
  assign bus.o_md_issue_rdy = w_issue_rdy;
  assign bus.o_sb_hit1      = r_busy[bus.i_rs1];
  assign bus.o_sb_hit2      = r_busy[bus.i_rs2];
  assign bus.o_rf_we3       = r_we3;
  assign bus.o_rf_a3        = r_a3;
  assign bus.o_rf_wd3       = r_wd3;
endmodule
